// File: rtl/wb_copy_master_pkg.sv
// wb_copy_master_pkg: shared state encoding and bus constants for the Wishbone copy master.
package wb_copy_master_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE,
        S_FAIL
    } state_t;
    localparam logic [3:0]  WB_SEL_WORD = 4'hF;
    localparam logic [31:0] ADR_STEP    = 32'd4;
endpackage

// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone B4 pipelined master copying len words from src to dst,
// one transfer outstanding at a time, with bus-error/timeout detection and abort.
module wb_copy_master
    import wb_copy_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [31:0]          src_adr_i,
    input  logic [31:0]          dst_adr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          err_adr_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [31:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic                 wb_stall_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic [31:0]          wb_dat_i
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state, state_nx;
    logic                 ready, start_ok, is_req, is_wait, is_rd, tmo_hit, fail;
    logic [31:0]          src, dst, data;
    logic [LEN_WIDTH-1:0] cnt;
    logic [TW-1:0]        tmo;

    assign is_rd    = state inside {S_RD_REQ, S_RD_WAIT};
    assign is_req   = state inside {S_RD_REQ, S_WR_REQ};
    assign is_wait  = state inside {S_RD_WAIT, S_WR_WAIT};
    // ready gates out a start on the very first edge after reset release
    assign start_ok = (state == S_IDLE) && start_i && ready;
    assign tmo_hit  = (32'(tmo) + 32'd1) >= TIMEOUT_CYCLES;
    assign fail     = is_wait && (wb_err_i || (!wb_ack_i && tmo_hit));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start_ok) state_nx = (len_i == '0) ? S_DONE : S_RD_REQ;
            S_RD_REQ:  if (!wb_stall_i) state_nx = S_RD_WAIT;
            S_RD_WAIT: state_nx = fail ? S_FAIL : wb_ack_i ? S_WR_REQ : S_RD_WAIT;
            S_WR_REQ:  if (!wb_stall_i) state_nx = S_WR_WAIT;
            S_WR_WAIT: state_nx = fail ? S_FAIL : !wb_ack_i ? S_WR_WAIT :
                                  (cnt == LEN_WIDTH'(1)) ? S_DONE : S_RD_REQ;
            default:   state_nx = S_IDLE;
        endcase
        if (abort_i && state != S_IDLE) state_nx = S_IDLE;
    end

    assign busy_o   = state != S_IDLE;
    assign done_o   = state == S_DONE;
    assign wb_cyc_o = is_req || is_wait;
    assign wb_stb_o = is_req;
    assign wb_we_o  = state inside {S_WR_REQ, S_WR_WAIT};
    assign wb_adr_o = !wb_cyc_o ? '0 : is_rd ? src : dst;
    assign wb_sel_o = is_req ? WB_SEL_WORD : 4'h0;
    assign wb_dat_o = data;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= S_IDLE;
            ready     <= 1'b0;
            src       <= '0;
            dst       <= '0;
            data      <= '0;
            cnt       <= '0;
            tmo       <= '0;
            err_o     <= 1'b0;
            err_adr_o <= '0;
        end else begin
            state <= state_nx;
            ready <= 1'b1;
            if (start_ok) begin
                src   <= src_adr_i;
                dst   <= dst_adr_i;
                cnt   <= len_i;
                err_o <= 1'b0;
            end
            if (is_req && !wb_stall_i) tmo <= '0;
            else if (is_wait && !wb_ack_i && !wb_err_i) tmo <= tmo + 1'b1;
            if (state == S_RD_WAIT && state_nx == S_WR_REQ) data <= wb_dat_i;
            if (state == S_WR_WAIT && state_nx inside {S_DONE, S_RD_REQ}) begin
                cnt <= cnt - 1'b1;
                src <= src + ADR_STEP;
                dst <= dst + ADR_STEP;
            end
            if (state_nx == S_FAIL) begin
                err_o     <= 1'b1;
                err_adr_o <= is_rd ? src : dst;
            end
        end
    end
endmodule
